// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared opcodes, FSM states and field constants for the GF(2^M) engine
//
// Contents:
//   OP_MUL / OP_INV : request opcode encoding on the op port
//   gf_state_e      : controller states of gf_mul_seq
//   POLY_AES        : x^8 + x^4 + x^3 + x + 1, the AES field polynomial
package gf_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_INV = 1'b1;

  localparam logic [8:0] POLY_AES = 9'h11B;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL     = 3'd1,
    INV_SQ  = 3'd2,
    INV_MUL = 3'd3,
    DONE    = 3'd4
  } gf_state_e;

endpackage

// File: rtl/gf_digit_step.sv
// rtl/gf_digit_step.sv - one combinational digit step of an MSB-first GF(2^M) multiply
//
// Computes acc_next = (acc * x^DIGIT mod POLY) xor (a * b_digit mod POLY).
// Ports:
//   acc      in  M      running partial product
//   a        in  M      multiplicand
//   b_digit  in  DIGIT  next DIGIT multiplier bits, MSB first
//   acc_next out M      updated partial product
module gf_digit_step
  import gf_pkg::*;
#(
  parameter int         M     = 8,
  parameter logic [M:0] POLY  = POLY_AES,
  parameter int         DIGIT = 1
) (
  input  logic [M-1:0]     acc,
  input  logic [M-1:0]     a,
  input  logic [DIGIT-1:0] b_digit,
  output logic [M-1:0]     acc_next
);

  logic [M-1:0] t;

  // Horner form: shift-reduce once per bit, folding in a where the multiplier
  // bit is set. By linearity this equals the acc*x^DIGIT xor a*b_digit form.
  always_comb begin
    t = acc;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      t = {t[M-2:0], 1'b0} ^ (t[M-1] ? POLY[M-1:0] : {M{1'b0}});
      if (b_digit[i]) begin
        t = t ^ a;
      end
    end
    acc_next = t;
  end

endmodule

// File: rtl/gf_mul_seq.sv
// rtl/gf_mul_seq.sv - sequential GF(2^M) multiplier / inverter with valid-ready handshakes
//
// MUL: result = a*b mod POLY in M/DIGIT cycles.
// INV: result = a^(2^M-2) via 2M-3 back-to-back multiplies (0 maps to 0).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready only in IDLE)
//   op, a, b             opcode (OP_MUL / OP_INV) and operands
//   out_valid/out_ready  result handshake (held in DONE until accepted)
//   result               registered result, holds last delivered value
//   busy                 high whenever not IDLE
module gf_mul_seq
  import gf_pkg::*;
#(
  parameter int         M     = 8,
  parameter logic [M:0] POLY  = POLY_AES,
  parameter int         DIGIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] result,
  output logic         busy
);

  localparam int CW    = 5;
  localparam int STEPS = M / DIGIT;

  if (M < 2 || M > 16) begin : g_bad_m
    $error("gf_mul_seq: M must be in 2..16");
  end
  if (DIGIT < 1 || (M % DIGIT) != 0) begin : g_bad_digit
    $error("gf_mul_seq: DIGIT must divide M");
  end
  if (POLY[M] != 1'b1) begin : g_bad_poly
    $error("gf_mul_seq: POLY bit M must be set");
  end

  gf_state_e     state_q, state_d;
  logic [M-1:0]  acc_q, acc_d;
  logic [M-1:0]  ma_q, ma_d;        // multiplicand of the running multiply
  logic [M-1:0]  mb_q, mb_d;        // multiplier, shifted left one digit per step
  logic [CW-1:0] cnt_q, cnt_d;      // digit steps done in the running multiply
  logic [CW-1:0] sq_cnt_q, sq_cnt_d; // squarings completed during INV
  logic [M-1:0]  r_q, r_d;
  logic [M-1:0]  s_q, s_d;
  logic [M-1:0]  result_q, result_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  logic [M-1:0]  prod;
  logic          last_step;

  gf_digit_step #(
    .M     (M),
    .POLY  (POLY),
    .DIGIT (DIGIT)
  ) u_step (
    .acc      (acc_q),
    .a        (ma_q),
    .b_digit  (mb_q[M-1 -: DIGIT]),
    .acc_next (prod)
  );

  assign last_step = (cnt_q == CW'(STEPS - 1));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    cnt_d    = cnt_q;
    sq_cnt_d = sq_cnt_q;
    r_d      = r_q;
    s_d      = s_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d    = '0;
          cnt_d    = '0;
          sq_cnt_d = '0;
          ma_d     = a;
          if (op == OP_INV) begin
            mb_d    = a;
            state_d = INV_SQ;
          end else begin
            mb_d    = b;
            state_d = MUL;
          end
        end
      end

      MUL, INV_SQ, INV_MUL: begin
        acc_d = prod;
        mb_d  = mb_q << DIGIT;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          // The next multiply (if any) starts on this same edge, so the
          // sub-multiplies of an inversion run without gaps.
          acc_d = '0;
          cnt_d = '0;
          if (state_q == MUL) begin
            result_d = prod;
            state_d  = DONE;
          end else if (state_q == INV_SQ) begin
            s_d      = prod;
            sq_cnt_d = sq_cnt_q + CW'(1);
            if (sq_cnt_q == '0) begin
              // First squaring seeds both r and s with a^2.
              r_d = prod;
              if (M == 2) begin
                result_d = prod;
                state_d  = DONE;
              end else begin
                ma_d = prod;
                mb_d = prod;
              end
            end else begin
              ma_d    = r_q;
              mb_d    = prod;
              state_d = INV_MUL;
            end
          end else begin
            r_d = prod;
            if (sq_cnt_q == CW'(M - 1)) begin
              result_d = prod;
              state_d  = DONE;
            end else begin
              ma_d    = s_q;
              mb_d    = s_q;
              state_d = INV_SQ;
            end
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      cnt_q       <= '0;
      sq_cnt_q    <= '0;
      r_q         <= '0;
      s_q         <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      cnt_q       <= cnt_d;
      sq_cnt_q    <= sq_cnt_d;
      r_q         <= r_d;
      s_q         <= s_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: doc/gf_mul_seq.md
GF_MUL_SEQ -- requirements
Module: gf_mul_seq

Interface
REQ-001 SHALL have parameter M, default 8, meaning field degree (GF(2^M)), legal range 2..16.
REQ-002 SHALL have parameter POLY, default 9'h11B, meaning the (M+1)-bit irreducible polynomial with bit M set.
REQ-003 SHALL have parameter DIGIT, default 1, meaning multiplier bits consumed per cycle; DIGIT must divide M.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a request.
REQ-008 SHALL have port op  input  1  0 = MUL (a·b), 1 = INV (a^-1, b ignored).
REQ-009 SHALL have ports a and b  input  M  operands.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  M  product or inverse, reduced mod POLY.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL use FSM states IDLE, MUL, INV_SQ, INV_MUL, DONE.
REQ-015 SHALL assert in_ready only in IDLE; accept a request on an edge where in_valid && in_ready, latching op, a and b.
REQ-016 SHALL perform each field multiply MSB-first, digit-serial: acc <= (acc·x^DIGIT mod POLY) xor (a·b_digit mod POLY), acc cleared at the start of each multiply, taking exactly M/DIGIT cycles.
REQ-017 SHALL, for MUL, enter DONE with out_valid high exactly M/DIGIT cycles after the accept edge.
REQ-018 SHALL compute INV as a^(2^M-2): r = s = a^2 (INV_SQ), then M-2 iterations of s = s^2 (INV_SQ) followed by r = r·s (INV_MUL), for 2M-3 back-to-back multiplies.
REQ-019 SHALL, for INV, enter DONE with out_valid high exactly (2M-3)·(M/DIGIT) cycles after the accept edge, with no idle cycles between sub-multiplies.
REQ-020 SHALL return result 0 for INV of a = 0 (natural outcome of the exponentiation; no special case).
REQ-021 SHALL hold result and out_valid stable in DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-022 SHALL keep result registered; result is don't-care-free: it holds the last delivered value while not in DONE.
REQ-023 SHALL ignore in_valid, op, a and b while busy, and SHALL ignore out_ready outside DONE.
REQ-024 SHALL make a new request acceptable one cycle after the output handshake (in_ready high in the following IDLE cycle).
REQ-025 SHALL fail elaboration if POLY[M] = 0, M/DIGIT is not an integer, or M is outside 2..16.

Reset
REQ-026 SHALL, on rst asserted at any time including mid-operation, immediately abort, enter IDLE, and drive in_ready = 1 after release, out_valid = 0, busy = 0, result = 0, and clear all internal registers.
REQ-027 SHALL not deliver any result for a request aborted by reset.

Structure
REQ-028 SHALL place the op encoding (OP_MUL, OP_INV), the state enum and the AES constant POLY_AES = 9'h11B in shared package gf_pkg.
REQ-029 SHALL implement the one-digit step (REQ-016) as combinational sub-module gf_digit_step, parameterised by M, POLY, DIGIT.

Verification
REQ-030 SHALL cover MUL, M=8, POLY=11B, DIGIT=1: a=57, b=83 -> result=C1, out_valid exactly 8 cycles after accept.
REQ-031 SHALL cover INV, M=8, POLY=11B, DIGIT=1: a=53 -> result=CA after 104 cycles; a=00 -> result=00; a=01 -> result=01.
REQ-032 SHALL cover DIGIT=4, M=8: a=57, b=83 -> result=C1 after 2 cycles; INV a=53 -> CA after 26 cycles.
REQ-033 SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> result/out_valid stable, in_ready 0; new in_valid during that time is ignored.
REQ-034 SHALL cover reset mid-INV (cycle 50): rst pulse -> out_valid 0, result 0, busy 0; next request MUL 02·87 -> 15.
REQ-035 SHALL cover exhaustive self-check M=8: for all nonzero a, MUL(a, INV(a)) = 01.
